hp_hit_engine: RTL and testbench
================================

# hp_hit_engine

Parametrised, multi-channel successor to the single-bullet collision/damage path in the game top level. Once per game frame it scans N bullet slots against the player's bounding box, one slot per clock. It applies the first qualifying hit (damage or heal) to a saturating HP register and enforces an invulnerability window counted in game ticks. It sits between the bullet generator and the game-state machine, driving player HP and death status.

## Interface
- N_BULLETS, 8: number of bullet slots scanned (≥1)
- COORD_W, 8: width of each coordinate and size field
- HP_W, 8: HP register width
- HP_MAX, 100: reset/restore HP value, and ceiling for healing
- DMG, 5: HP removed per damage hit
- HEAL, 3: HP added per heal hit
- IFRAME_TICKS, 10: invulnerability length in `tick` pulses
- clk in 1: system clock, all logic rising-edge
- reset_n in 1: asynchronous, active-low reset
- tick in 1: one-cycle game-tick strobe (10 Hz domain, pre-synchronised)
- start in 1: one-cycle request to begin a scan
- hp_restore in 1: reload HP_MAX and clear dead/invulnerability
- player_x, player_y in COORD_W: player box origin
- player_w, player_h in COORD_W: player box size
- bullet_x, bullet_y in N_BULLETS*COORD_W: slot i occupies bits [i*COORD_W +: COORD_W]
- bullet_w, bullet_h in N_BULLETS*COORD_W: slot sizes, same packing
- bullet_color in N_BULLETS*3: slot colour codes
- bullet_valid in N_BULLETS: slot active
- hp out HP_W: current HP
- dead out 1: HP is zero, sticky
- busy out 1: scan in progress
- done out 1: one-cycle scan-complete pulse
- hit_pulse out 1: one-cycle, damage applied this scan
- heal_pulse out 1: one-cycle, heal applied this scan
- hit_index out clog2(N_BULLETS) (min 1): slot of last applied event

## Operation
- FSM states: IDLE, SCAN, APPLY. Reset state is IDLE.
- IDLE → SCAN when start=1. On the same edge: latch the player box, set index to 0, clear the pending event.
- SCAN: each cycle, evaluate slot `index`.
  - A slot qualifies when valid=1, colour≠COLOR_INERT, and the boxes overlap.
  - The first qualifying slot in ascending index order is recorded as the pending event, with its index and kind. Kind is heal if colour==COLOR_HEAL, otherwise damage. Later slots are ignored.
  - After slot N_BULLETS-1 is evaluated → APPLY.
- APPLY, one cycle, then → IDLE:
  - Damage with iframe==0 and dead=0: hp ← max(hp−DMG, 0), iframe ← IFRAME_TICKS, hit_pulse=1, hit_index updated.
  - Damage with iframe≠0: discarded, no pulse.
  - Heal with dead=0: hp ← min(hp+HEAL, HP_MAX), heal_pulse=1, hit_index updated. Heal is not blocked by iframe.
  - Any event while dead=1 is discarded.
  - done=1 every APPLY, whether or not an event was applied.
- dead is registered (hp==0) after each update. It stays set until hp_restore.
- Bullet inputs are sampled live during SCAN. The producer holds them stable from start until done. The player box is snapshotted at start.
- Overlap rule, on COORD_W+1-bit sums so there is no wrap: ax < bx+bw and bx < ax+aw, on both axes. A zero width or height on either box never overlaps.
- All outputs are registered. Reset values: hp=HP_MAX, dead=0, busy=0, done=0, hit_pulse=0, heal_pulse=0, hit_index=0. Internal iframe=0.

## Timing
- start sampled at edge t. SCAN occupies cycles t+1..t+N_BULLETS. APPLY is cycle t+N_BULLETS+1.
- busy is high over t+1..t+N_BULLETS+1. done, pulses and new hp are visible in the APPLY cycle.
- start while busy is ignored. start in the APPLY cycle is ignored. start is accepted in the first IDLE cycle after APPLY.
- tick with iframe>0 decrements iframe. If a tick coincides with an iframe load in APPLY, the load wins.
- hp_restore is honoured in any state: hp ← HP_MAX, dead ← 0, iframe ← 0. If it coincides with APPLY, restore wins and the event pulses are suppressed. The scan itself continues.
- reset_n asserted mid-scan: immediate return to IDLE with reset values. No done is issued.

## Configuration
- HP_HIT_ENGINE_HEAL_EN defined: heal behaviour as above.
- Not defined: COLOR_HEAL is treated as a damage colour, heal_pulse is tied 0, and the HEAL parameter is unused.

## Structure
- Package hit_engine_pkg holds:
  - colour codes COLOR_INERT=3'd0 and COLOR_HEAL=3'd2
  - FSM state typedef (IDLE/SCAN/APPLY)
  - event-kind typedef (NONE/DAMAGE/HEAL)
- Sub-module box_overlap: combinational overlap test, parametrised by COORD_W, instantiated once on the slot selected by index.

## Test plan
- Reset, then N=8, player (50,50,16,16), slot 3 valid, damage colour 3'd4 at (60,60,4,4), start → done at cycle 9 after start, hp 100→95, hit_pulse=1, hit_index=3.
- Slots 2 (heal) and 5 (damage) both overlapping, hp=90 → only slot 2 applied, hp=93, heal_pulse=1, hit_index=2. hp=99 → hp=100, saturated.
- Two damage scans with no tick between → second scan done=1, hit_pulse=0, hp unchanged. After 10 ticks, third scan → hp−5.
- hp=3, damage hit → hp=0, dead=1. Further heal scan → hp stays 0. hp_restore → hp=100, dead=0.
- Edge touch: player (50,50,16,16), bullet at (66,50,4,4) → no hit. Bullet (250,250,10,10) with player (245,245,8,8) → hit, no wrap. Bullet w=0 → no hit.
- start re-asserted during busy → ignored, single done. reset_n pulsed at SCAN cycle 4 → busy=0, hp=100, no done.

Source files
------------

// File: rtl/hit_engine_pkg.sv
// hit_engine_pkg: shared colour codes, FSM states and event kinds for hp_hit_engine
package hit_engine_pkg;
  localparam logic [2:0] COLOR_INERT = 3'd0;
  localparam logic [2:0] COLOR_HEAL  = 3'd2;
  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_e;
  // Prefixed so they do not collide with the HEAL parameter of the top module.
  typedef enum logic [1:0] {EV_NONE, EV_DAMAGE, EV_HEAL} kind_e;
endpackage

// File: rtl/hp_hit_engine_box_overlap.sv
// box_overlap: combinational axis-aligned box overlap test.
//   ax_i/ay_i/aw_i/ah_i : box A origin and size
//   bx_i/by_i/bw_i/bh_i : box B origin and size
//   hit_o               : boxes overlap (edge contact and empty boxes do not count)
module box_overlap #(
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] ax_i,
  input  logic [COORD_W-1:0] ay_i,
  input  logic [COORD_W-1:0] aw_i,
  input  logic [COORD_W-1:0] ah_i,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  input  logic [COORD_W-1:0] bw_i,
  input  logic [COORD_W-1:0] bh_i,
  output logic               hit_o
);
  // One extra bit on the far edges so boxes near the top of the range do not wrap.
  always_comb
    hit_o = (|aw_i) && (|ah_i) && (|bw_i) && (|bh_i) &&
            ({1'b0, ax_i} < {1'b0, bx_i} + {1'b0, bw_i}) &&
            ({1'b0, bx_i} < {1'b0, ax_i} + {1'b0, aw_i}) &&
            ({1'b0, ay_i} < {1'b0, by_i} + {1'b0, bh_i}) &&
            ({1'b0, by_i} < {1'b0, ay_i} + {1'b0, ah_i});
endmodule

// File: rtl/hp_hit_engine.sv
// hp_hit_engine: per-frame bullet scan against the player box, driving saturating HP and death.
//   Optional feature macro: HP_HIT_ENGINE_HEAL_EN (heal-colour bullets restore HP).
//   clk, reset_n           : clock, asynchronous active-low reset
//   tick, start, hp_restore: game tick strobe, scan request, HP reload
//   player_*               : player box (snapshotted at start)
//   bullet_*               : packed slot arrays, slot i at [i*W +: W]
//   hp, dead               : current HP, sticky zero-HP flag
//   busy, done             : scan in progress, one-cycle completion pulse
//   hit_pulse, heal_pulse  : one-cycle applied-event pulses
//   hit_index              : slot of the last applied event
module hp_hit_engine
  import hit_engine_pkg::*;
#(
  parameter int N_BULLETS    = 8,
  parameter int COORD_W      = 8,
  parameter int HP_W         = 8,
  parameter int HP_MAX       = 100,
  parameter int DMG          = 5,
  parameter int HEAL         = 3,
  parameter int IFRAME_TICKS = 10,
  localparam int IW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   hp_restore,
  input  logic [COORD_W-1:0]     player_x,
  input  logic [COORD_W-1:0]     player_y,
  input  logic [COORD_W-1:0]     player_w,
  input  logic [COORD_W-1:0]     player_h,
  input  logic [N_BULLETS*COORD_W-1:0] bullet_x,
  input  logic [N_BULLETS*COORD_W-1:0] bullet_y,
  input  logic [N_BULLETS*COORD_W-1:0] bullet_w,
  input  logic [N_BULLETS*COORD_W-1:0] bullet_h,
  input  logic [N_BULLETS*3-1:0] bullet_color,
  input  logic [N_BULLETS-1:0]   bullet_valid,
  output logic [HP_W-1:0]        hp,
  output logic                   dead,
  output logic                   busy,
  output logic                   done,
  output logic                   hit_pulse,
  output logic                   heal_pulse,
  output logic [IW-1:0]          hit_index
);
  localparam int IFW = (IFRAME_TICKS > 1) ? $clog2(IFRAME_TICKS + 1) : 1;
  state_e state_q;
  kind_e pend_q, slot_kind, ev_kind;
  logic [COORD_W-1:0] px_q, py_q, pw_q, ph_q;
  logic [IW-1:0] idx_q, pend_idx_q, hit_index_q, ev_idx;
  logic [HP_W-1:0] hp_q, hp_d, hp_sub, hp_add;
  logic [IFW-1:0] iframe_q, iframe_d;
  logic [2:0] slot_color;
  logic ovl, qual, last, dmg_ok, heal_ok, dead_q, dead_d;
  logic busy_q, done_q, hit_pulse_q, heal_pulse_q;
  box_overlap #(.COORD_W(COORD_W)) u_ovl (
    .ax_i(px_q), .ay_i(py_q), .aw_i(pw_q), .ah_i(ph_q),
    .bx_i(bullet_x[idx_q*COORD_W +: COORD_W]),
    .by_i(bullet_y[idx_q*COORD_W +: COORD_W]),
    .bw_i(bullet_w[idx_q*COORD_W +: COORD_W]),
    .bh_i(bullet_h[idx_q*COORD_W +: COORD_W]),
    .hit_o(ovl)
  );
  always_comb begin
    slot_color = bullet_color[idx_q*3 +: 3];
    qual = bullet_valid[idx_q] && (slot_color != COLOR_INERT) && ovl;
`ifdef HP_HIT_ENGINE_HEAL_EN
    slot_kind = (slot_color == COLOR_HEAL) ? EV_HEAL : EV_DAMAGE;
`else
    slot_kind = EV_DAMAGE;
`endif
    last = (state_q == SCAN) && (idx_q == IW'(N_BULLETS - 1));
    // The final slot is resolved in the same cycle the update is committed.
    ev_kind = (pend_q != EV_NONE) ? pend_q : (qual ? slot_kind : EV_NONE);
    ev_idx = (pend_q != EV_NONE) ? pend_idx_q : idx_q;
    dmg_ok = last && (ev_kind == EV_DAMAGE) && (iframe_q == '0) && !dead_q && !hp_restore;
    hp_sub = (hp_q > HP_W'(DMG)) ? hp_q - HP_W'(DMG) : '0;
`ifdef HP_HIT_ENGINE_HEAL_EN
    heal_ok = last && (ev_kind == EV_HEAL) && !dead_q && !hp_restore;
    hp_add = ({1'b0, hp_q} + (HP_W+1)'(HEAL) >= (HP_W+1)'(HP_MAX)) ? HP_W'(HP_MAX) : hp_q + HP_W'(HEAL);
`else
    heal_ok = 1'b0;
    hp_add = hp_q;
`endif
    hp_d = hp_restore ? HP_W'(HP_MAX) : dmg_ok ? hp_sub : heal_ok ? hp_add : hp_q;
    iframe_d = hp_restore ? '0 : dmg_ok ? IFW'(IFRAME_TICKS) :
               (tick && (iframe_q != '0)) ? iframe_q - IFW'(1) : iframe_q;
    dead_d = !hp_restore && (dead_q || (hp_d == '0));
  end
`ifndef HP_HIT_ENGINE_HEAL_EN
  logic unused_heal;
  assign unused_heal = |HEAL;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q <= EV_NONE;
      pend_idx_q <= '0;
      idx_q <= '0;
      {px_q, py_q, pw_q, ph_q} <= '0;
      hp_q <= HP_W'(HP_MAX);
      iframe_q <= '0;
      dead_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_pulse_q <= 1'b0;
      heal_pulse_q <= 1'b0;
      hit_index_q <= '0;
    end else begin
      hp_q <= hp_d;
      iframe_q <= iframe_d;
      dead_q <= dead_d;
      done_q <= last;
      hit_pulse_q <= dmg_ok;
      heal_pulse_q <= heal_ok;
      if (dmg_ok || heal_ok) hit_index_q <= ev_idx;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SCAN;
          busy_q <= 1'b1;
          idx_q <= '0;
          pend_q <= EV_NONE;
          {px_q, py_q, pw_q, ph_q} <= {player_x, player_y, player_w, player_h};
        end
        SCAN: begin
          if ((pend_q == EV_NONE) && qual) begin
            pend_q <= slot_kind;
            pend_idx_q <= idx_q;
          end
          if (last) state_q <= APPLY;
          else idx_q <= idx_q + IW'(1);
        end
        APPLY: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign hp = hp_q;
  assign dead = dead_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hit_pulse = hit_pulse_q;
  assign heal_pulse = heal_pulse_q;
  assign hit_index = hit_index_q;
endmodule

// File: tb/tb_hp_hit_engine.sv
// tb_hp_hit_engine: directed self-checking bench for hp_hit_engine
module tb_hp_hit_engine;
`ifdef HP_HIT_ENGINE_HEAL_EN
  localparam bit HEAL_ON = 1'b1;
`else
  localparam bit HEAL_ON = 1'b0;
`endif
  logic clk = 0, reset_n = 0, tick = 0, start = 0, hp_restore = 0;
  logic [7:0] player_x, player_y, player_w, player_h;
  logic [63:0] bullet_x, bullet_y, bullet_w, bullet_h;
  logic [23:0] bullet_color;
  logic [7:0] bullet_valid;
  logic [7:0] hp;
  logic dead, busy, done, hit_pulse, heal_pulse;
  logic [2:0] hit_index;
  int vec = 0, miscomp = 0;
  hp_hit_engine dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .hp_restore(hp_restore),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_w(bullet_w), .bullet_h(bullet_h),
    .bullet_color(bullet_color), .bullet_valid(bullet_valid),
    .hp(hp), .dead(dead), .busy(busy), .done(done),
    .hit_pulse(hit_pulse), .heal_pulse(heal_pulse), .hit_index(hit_index)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    if (obs != exp) begin
      miscomp++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_slots();
    bullet_x = '0; bullet_y = '0; bullet_w = '0; bullet_h = '0;
    bullet_color = '0; bullet_valid = '0;
  endtask
  task automatic set_player(input int x, input int y, input int w, input int h);
    player_x = 8'(x); player_y = 8'(y); player_w = 8'(w); player_h = 8'(h);
  endtask
  task automatic set_slot(input int i, input int x, input int y, input int w, input int h, input int c);
    bullet_x[i*8 +: 8] = 8'(x); bullet_y[i*8 +: 8] = 8'(y);
    bullet_w[i*8 +: 8] = 8'(w); bullet_h[i*8 +: 8] = 8'(h);
    bullet_color[i*3 +: 3] = 3'(c); bullet_valid[i] = 1'b1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; step(1);
      tick = 0; step(1);
    end
  endtask
  // Starts a scan from IDLE and returns at the APPLY cycle (latency counted from the start edge).
  task automatic scan(input string tag);
    int lat;
    step(1);
    start = 1; step(1); start = 0;
    chk({tag, ".busy"}, int'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      step(1);
    end
    chk({tag, ".lat"}, lat, 9);
  endtask
  initial begin
    int dones;
    clear_slots();
    set_player(50, 50, 16, 16);
    step(2);
    chk("rst.hp", int'(hp), 100);
    chk("rst.dead", int'(dead), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.hit", int'(hit_pulse), 0);
    chk("rst.heal", int'(heal_pulse), 0);
    chk("rst.idx", int'(hit_index), 0);
    reset_n = 1;
    step(1);
    set_slot(3, 60, 60, 4, 4, 4);
    scan("dmg1");
    chk("dmg1.hp", int'(hp), 95);
    chk("dmg1.hit", int'(hit_pulse), 1);
    chk("dmg1.heal", int'(heal_pulse), 0);
    chk("dmg1.idx", int'(hit_index), 3);
    step(1);
    chk("dmg1.done_off", int'(done), 0);
    chk("dmg1.hit_off", int'(hit_pulse), 0);
    scan("ifr");
    chk("ifr.hp", int'(hp), 95);
    chk("ifr.hit", int'(hit_pulse), 0);
    ticks(10);
    scan("dmg2");
    chk("dmg2.hp", int'(hp), 90);
    chk("dmg2.hit", int'(hit_pulse), 1);
    clear_slots();
    set_slot(2, 52, 52, 4, 4, 2);
    set_slot(5, 55, 55, 4, 4, 4);
    scan("heal1");
    chk("heal1.hp", int'(hp), HEAL_ON ? 93 : 90);
    chk("heal1.heal", int'(heal_pulse), HEAL_ON ? 1 : 0);
    chk("heal1.hit", int'(hit_pulse), 0);
    chk("heal1.idx", int'(hit_index), HEAL_ON ? 2 : 3);
    scan("heal2");
    chk("heal2.hp", int'(hp), HEAL_ON ? 96 : 90);
    scan("heal3");
    chk("heal3.hp", int'(hp), HEAL_ON ? 99 : 90);
    scan("heal4");
    chk("heal4.hp", int'(hp), HEAL_ON ? 100 : 90);
    chk("heal4.heal", int'(heal_pulse), HEAL_ON ? 1 : 0);
    hp_restore = 1; step(1); hp_restore = 0;
    chk("rest1.hp", int'(hp), 100);
    clear_slots();
    set_slot(3, 60, 60, 4, 4, 4);
    for (int i = 0; i < 19; i++) begin
      ticks(10);
      scan("drain");
    end
    chk("drain.hp", int'(hp), 5);
    if (HEAL_ON) begin
      clear_slots();
      set_slot(1, 60, 60, 4, 4, 2);
      scan("up");
      chk("up.hp", int'(hp), 8);
      clear_slots();
      set_slot(3, 60, 60, 4, 4, 4);
      ticks(10);
      scan("low");
      chk("low.hp", int'(hp), 3);
    end
    ticks(10);
    scan("kill");
    chk("kill.hp", int'(hp), 0);
    chk("kill.dead", int'(dead), 1);
    chk("kill.hit", int'(hit_pulse), 1);
    clear_slots();
    set_slot(0, 60, 60, 4, 4, 2);
    ticks(10);
    scan("deadheal");
    chk("deadheal.hp", int'(hp), 0);
    chk("deadheal.heal", int'(heal_pulse), 0);
    chk("deadheal.hit", int'(hit_pulse), 0);
    chk("deadheal.dead", int'(dead), 1);
    hp_restore = 1; step(1); hp_restore = 0;
    chk("rest2.hp", int'(hp), 100);
    chk("rest2.dead", int'(dead), 0);
    clear_slots();
    set_slot(0, 66, 50, 4, 4, 4);
    set_slot(1, 46, 50, 4, 4, 4);
    set_slot(2, 50, 66, 4, 4, 4);
    scan("touch");
    chk("touch.hit", int'(hit_pulse), 0);
    chk("touch.hp", int'(hp), 100);
    clear_slots();
    set_player(245, 245, 8, 8);
    set_slot(0, 250, 250, 10, 10, 4);
    scan("wrap");
    chk("wrap.hit", int'(hit_pulse), 1);
    chk("wrap.hp", int'(hp), 95);
    chk("wrap.idx", int'(hit_index), 0);
    clear_slots();
    set_player(50, 50, 16, 16);
    set_slot(4, 55, 55, 0, 4, 4);
    set_slot(6, 55, 55, 4, 0, 4);
    ticks(10);
    scan("zero");
    chk("zero.hit", int'(hit_pulse), 0);
    chk("zero.hp", int'(hp), 95);
    clear_slots();
    set_slot(3, 60, 60, 4, 4, 4);
    step(1);
    start = 1; step(3); start = 0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) dones++;
      step(1);
    end
    chk("rearm.dones", dones, 1);
    chk("rearm.hp", int'(hp), 90);
    ticks(10);
    step(1);
    start = 1; step(1); start = 0;
    step(3);
    chk("mid.busy_pre", int'(busy), 1);
    reset_n = 0;
    #1;
    chk("mid.busy", int'(busy), 0);
    chk("mid.hp", int'(hp), 100);
    chk("mid.done", int'(done), 0);
    #1 reset_n = 1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      if (done) dones++;
    end
    chk("mid.dones", dones, 0);
    chk("mid.idle", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end
endmodule
